// File: rtl/axi_lite_addsub_bank.sv
// AXI4-Lite slave holding C_NUM_CHANNELS independent add/sub channels.
// Results and flags update on the same edge as the operand/mode write.
module axi_lite_addsub_bank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_CHANNELS     = 4,
  parameter int C_OPERAND_WIDTH    = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          irq,
  output logic [0:0]                    o_dbg_wr_state
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int N  = C_NUM_CHANNELS;
  localparam int W  = C_OPERAND_WIDTH;
  localparam int CW = AW - 4;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [AW-3:0] WD_CTRL  = 0;
  localparam logic [AW-3:0] WD_OPCNT = 1;
  localparam logic [AW-3:0] WD_STAT  = 2;

  // Handshakes: a transfer happens on an edge where VALID and READY are both
  // high; READY pulses one cycle, VALID/BVALID/RVALID hold until accepted.
  logic [0:0]          r_wstate;
  logic                r_awready, r_wready, r_aw_got, r_w_got, r_bvalid;
  logic [1:0]          r_bresp;
  logic [AW-1:0]       r_awaddr;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wstrb;
  logic                r_arready, r_rvalid;
  logic [1:0]          r_rresp;
  logic [31:0]         r_rdata;
  logic [N-1:0]        r_mode, r_status;
  logic                r_irq_en;
  logic [31:0]         r_opcount;
  logic [N-1:0][W-1:0] r_a, r_b, r_result;
  logic [N-1:0][1:0]   r_flags;

  logic                w_do_write, w_wr_err, w_irq_en_nxt, w_rd_err;
  logic [AW-3:0]       w_wr_word, w_rd_word;
  logic [31:0]         w_ctrl_word, w_tmp, w_inc, w_rd_data;
  logic [N-1:0]        w_mode_nxt, w_recalc, w_clr, w_cb_nxt;
  logic [N-1:0][W-1:0] w_a_nxt, w_b_nxt, w_res_nxt;
  logic [N-1:0][W:0]   w_sum, w_dif;
  logic                w_unused;

  function automatic logic [31:0] f_strb(input logic [31:0] old_v,
                                         input logic [31:0] data,
                                         input logic [3:0]  strb);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) res[8*k +: 8] = strb[k] ? data[8*k +: 8] : old_v[8*k +: 8];
    return res;
  endfunction

  assign w_do_write  = (r_wstate == W_IDLE) && r_aw_got && r_w_got;
  assign w_wr_word   = r_awaddr[AW-1:2];
  assign w_rd_word   = S_AXI_ARADDR[AW-1:2];
  assign w_ctrl_word = {r_irq_en, {(31-N){1'b0}}, r_mode};

  always_comb begin
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_mode_nxt   = r_mode;
    w_irq_en_nxt = r_irq_en;
    w_recalc     = '0;
    w_clr        = '0;
    w_wr_err     = 1'b0;
    w_tmp        = '0;
    if (w_do_write) begin
      w_wr_err = 1'b1;
      if (w_wr_word == WD_CTRL) begin
        w_tmp        = f_strb(w_ctrl_word, r_wdata, r_wstrb);
        w_mode_nxt   = w_tmp[N-1:0];
        w_irq_en_nxt = w_tmp[31];
        w_recalc     = w_mode_nxt ^ r_mode;
        w_wr_err     = 1'b0;
      end else if (w_wr_word == WD_STAT) begin
        w_tmp    = f_strb(32'h0, r_wdata, r_wstrb);
        w_clr    = w_tmp[N-1:0];
        w_wr_err = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (w_wr_word[AW-3:2] == CW'(i + 1)) begin
            if (w_wr_word[1:0] == 2'd0) begin
              w_tmp       = f_strb(32'(r_a[i]), r_wdata, r_wstrb);
              w_a_nxt[i]  = w_tmp[W-1:0];
              w_recalc[i] = 1'b1;
              w_wr_err    = 1'b0;
            end else if (w_wr_word[1:0] == 2'd1) begin
              w_tmp       = f_strb(32'(r_b[i]), r_wdata, r_wstrb);
              w_b_nxt[i]  = w_tmp[W-1:0];
              w_recalc[i] = 1'b1;
              w_wr_err    = 1'b0;
            end
          end
        end
      end
    end
  end

  // Compute from the post-write operands so results land with the write.
  always_comb begin
    w_sum     = '0;
    w_dif     = '0;
    w_res_nxt = '0;
    w_cb_nxt  = '0;
    w_inc     = '0;
    for (int i = 0; i < N; i++) begin
      w_sum[i]     = {1'b0, w_a_nxt[i]} + {1'b0, w_b_nxt[i]};
      w_dif[i]     = {1'b0, w_a_nxt[i]} - {1'b0, w_b_nxt[i]};
      w_res_nxt[i] = w_mode_nxt[i] ? w_dif[i][W-1:0] : w_sum[i][W-1:0];
      w_cb_nxt[i]  = w_mode_nxt[i] ? w_dif[i][W] : w_sum[i][W];
      w_inc        = w_inc + 32'(w_recalc[i]);
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    if (w_rd_word == WD_CTRL) begin
      w_rd_data = w_ctrl_word;
      w_rd_err  = 1'b0;
    end else if (w_rd_word == WD_OPCNT) begin
      w_rd_data = r_opcount;
      w_rd_err  = 1'b0;
    end else if (w_rd_word == WD_STAT) begin
      w_rd_data = 32'(r_status);
      w_rd_err  = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_rd_word[AW-3:2] == CW'(i + 1)) begin
          w_rd_err = 1'b0;
          case (w_rd_word[1:0])
            2'd0:    w_rd_data = 32'(r_a[i]);
            2'd1:    w_rd_data = 32'(r_b[i]);
            2'd2:    w_rd_data = 32'(r_result[i]);
            default: w_rd_data = 32'(r_flags[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      if ((r_wstate == W_IDLE) && S_AXI_AWVALID && !r_aw_got && !r_awready) r_awready <= 1'b1;
      if ((r_wstate == W_IDLE) && S_AXI_WVALID && !r_w_got && !r_wready) r_wready <= 1'b1;
      if (r_awready && S_AXI_AWVALID) begin
        r_awaddr <= S_AXI_AWADDR;
        r_aw_got <= 1'b1;
      end
      if (r_wready && S_AXI_WVALID) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
        r_w_got <= 1'b1;
      end
      case (r_wstate)
        W_IDLE: if (w_do_write) begin
          r_aw_got <= 1'b0;
          r_w_got  <= 1'b0;
          r_bvalid <= 1'b1;
          r_bresp  <= w_wr_err ? RESP_SLVERR : RESP_OKAY;
          r_wstate <= W_RESP;
        end
        default: if (S_AXI_BREADY) begin
          r_bvalid <= 1'b0;
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_mode    <= '0;
      r_irq_en  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_opcount <= '0;
      r_status  <= '0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_irq_en  <= w_irq_en_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_opcount <= r_opcount + w_inc;
      // A sticky set beats a W1C clear of the same bit.
      r_status  <= (r_status & ~w_clr) | (w_recalc & w_cb_nxt);
      for (int i = 0; i < N; i++) begin
        if (w_recalc[i]) begin
          r_result[i] <= w_res_nxt[i];
          r_flags[i]  <= {(w_res_nxt[i] == '0), w_cb_nxt[i]};
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= 1'b0;
      if (S_AXI_ARVALID && !r_arready && !r_rvalid) r_arready <= 1'b1;
      if (r_arready && S_AXI_ARVALID) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY  = r_awready;
  assign S_AXI_WREADY   = r_wready;
  assign S_AXI_BVALID   = r_bvalid;
  assign S_AXI_BRESP    = r_bresp;
  assign S_AXI_ARREADY  = r_arready;
  assign S_AXI_RVALID   = r_rvalid;
  assign S_AXI_RDATA    = r_rdata;
  assign S_AXI_RRESP    = r_rresp;
  assign irq            = r_irq_en && (|r_status);
  assign o_dbg_wr_state = r_wstate;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      r_awaddr[1:0], w_tmp};
endmodule
